nios_system_sdram_nios2_qsys_0_jtag_monitor_mem: RTL and testbench
==================================================================

// Module: nios_system_sdram_nios2_qsys_0_jtag_monitor_mem
// PURPOSE
// Consumes the sysclk-domain JTAG debug strobes (take_action_ocimem_a/b, take_no_action_ocimem_a)
// and the 38-bit jdo word, and owns the debug monitor RAM, address register and MonDReg.
// Returns MonDReg, monitor_ready and monitor_error to the JTAG debug module for scan-out.
// A debug Avalon slave port gives the CPU's monitor code access to the same RAM and a control word.
// PARAMETERS
// ADDR_W  8  word-address width; RAM depth 2**ADDR_W - 1 (top address = control word); legal 4..16
// PORTS
// clk                      in   1       system clock
// reset_n                  in   1       async active-low reset
// jdo                      in   38      JTAG data word, already synchronised to clk
// take_action_ocimem_a     in   1       JTAG command strobe (address / read / control)
// take_action_ocimem_b     in   1       JTAG write-data strobe
// take_no_action_ocimem_a  in   1       JTAG auto-increment read strobe
// av_address               in   ADDR_W  Avalon word address
// av_read / av_write       in   1       Avalon read / write request
// av_writedata             in   32      Avalon write data
// av_byteenable            in   4       Avalon byte lanes
// av_waitrequest           out  1       Avalon stall (combinational)
// av_readdata              out  32      Avalon read data (registered)
// av_readdatavalid         out  1       one-cycle read-data qualifier
// MonDReg                  out  32      monitor data register to JTAG
// monitor_ready            out  1       CPU monitor ready flag
// monitor_error            out  1       CPU monitor error flag
// monitor_go               out  1       JTAG request for the monitor to run
// BEHAVIOUR
// - Reset (async, reset_n=0): MonDReg=0, MonAReg=0, flags=0, av_readdata=0, av_readdatavalid=0,
//   jtag_rd_pend=0. RAM contents are not reset. A reset mid-access drops the access; no write completes.
// - take_action_ocimem_a: MonAReg<=jdo[ADDR_W+9:10]. jdo[35]=1 issues a RAM read at the new address.
//   jdo[34]=1 sets go; jdo[33]=1 clears error; jdo[32]=1 clears ready.
// - take_no_action_ocimem_a: when the last command was a read, MonAReg<=MonAReg+1 and a read issues there.
// - take_action_ocimem_b: RAM[MonAReg]<=jdo[34:3] (all lanes); MonDReg<=jdo[34:3]; MonAReg<=MonAReg+1.
// - MonAReg wraps from 2**ADDR_W-1 to 0. The JTAG path never touches the control word:
//   a JTAG access at the top address is a no-op on RAM; MonAReg still updates.
// - JTAG read latency: RAM is sync, so MonDReg<=RAM data 2 cycles after the strobe (issue, RAM, capture).
// - Arbitration: JTAG strobes have absolute priority. av_waitrequest=1 in any cycle carrying a JTAG
//   strobe, and also in the cycle after a JTAG read issue. Otherwise av_waitrequest=0.
// - Avalon RAM access (address < top): a write honours byteenable.
//   An accepted read gives av_readdatavalid=1 and av_readdata exactly 2 cycles later.
// - Avalon control word (address = top):
//   * write: bit0=1 sets ready, bit1=1 sets error (0 bits are no effect).
//   * read: returns {29'b0, go, error, ready}, same latency, and clears go on acceptance.
// - Simultaneous events: a JTAG clear of ready/error beats an Avalon set in the same cycle.
//   A JTAG set of go beats an Avalon read-clear. Avalon read and write never assert together (no check).
// - The three JTAG strobes are mutually exclusive by construction upstream. If more than one is seen,
//   priority is b > a > no_action.
// TESTING
// - After reset, JTAG cmd_a jdo[17:10]=8'h10, jdo[35]=0, then cmd_b jdo[34:3]=32'hDEADBEEF
//   -> RAM[0x10]=DEADBEEF, MonAReg=0x11, MonDReg=DEADBEEF.
// - cmd_a jdo[35]=1 addr 0x10, then no_action x2 -> MonDReg=RAM[0x10] 2 cycles after the first strobe,
//   followed by RAM[0x11] and RAM[0x12].
// - MonAReg=0xFE, cmd_b x3 -> writes 0xFE, skips 0xFF (control word), then MonAReg=0x01.
//   av read 0x00 -> the third data word.
// - av_read at 0x20 on the same cycle as cmd_a -> waitrequest=1 that cycle and the next;
//   read accepted after, data valid 2 cycles later.
// - av_write 0xFF data=3 on the same cycle as cmd_a jdo[32]=1 -> ready=0, error=1.
//   av read 0xFF -> 32'h2 (go=0).
// - cmd_a jdo[34]=1 -> go=1. Assert reset_n=0 mid-cmd_b -> all outputs 0 at once; RAM target unchanged.

Source files
------------

// File: rtl/nios_system_sdram_nios2_qsys_0_jtag_monitor_mem_if.sv
// Debug Avalon slave bus between the CPU's monitor code and the JTAG monitor memory.
interface nios_system_sdram_nios2_qsys_0_jtag_monitor_mem_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] av_address;
    logic              av_read;
    logic              av_write;
    logic [31:0]       av_writedata;
    logic [3:0]        av_byteenable;
    logic              av_waitrequest;
    logic [31:0]       av_readdata;
    logic              av_readdatavalid;

    modport master (
        output av_address, av_read, av_write, av_writedata, av_byteenable,
        input  av_waitrequest, av_readdata, av_readdatavalid
    );

    modport slave (
        input  av_address, av_read, av_write, av_writedata, av_byteenable,
        output av_waitrequest, av_readdata, av_readdatavalid
    );
endinterface

// File: rtl/nios_system_sdram_nios2_qsys_0_jtag_monitor_mem.sv
// JTAG debug monitor memory: RAM, address register and MonDReg shared between the JTAG
// command strobes and a debug Avalon slave; the top word address is the monitor control word.
module nios_system_sdram_nios2_qsys_0_jtag_monitor_mem #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic        take_no_action_ocimem_a,
    nios_system_sdram_nios2_qsys_0_jtag_monitor_mem_if.slave av,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error,
    output logic        monitor_go
);
    localparam int                DEPTH = (1 << ADDR_W) - 1;
    localparam logic [ADDR_W-1:0] TOP   = '1;
    localparam logic [ADDR_W-1:0] INC   = ADDR_W'(1);

    logic              strobe_a, strobe_b, strobe_n;
    logic [ADDR_W-1:0] mon_addr_reg, mon_addr_next;
    logic              last_rd_reg;
    logic              jtag_rd_req, jtag_rd_issue, jtag_rd_pend_reg, jtag_wr;
    logic              av_rd_acc, av_wr_acc, av_is_top, ctrl_wr;
    logic              av_rd_pend_reg, av_rd_ctrl_reg;
    logic [2:0]        ctrl_snap_reg;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [ADDR_W-1:0] ram_wa, ram_ra;
    logic [31:0]       ram_wd, ram_q;
    logic              unused_jdo;

    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    // Upstream keeps the strobes exclusive; if not, b beats a beats no_action.
    assign strobe_b = take_action_ocimem_b;
    assign strobe_a = take_action_ocimem_a & ~take_action_ocimem_b;
    assign strobe_n = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;

    always_comb begin
        mon_addr_next = mon_addr_reg;
        jtag_rd_req   = 1'b0;
        if (strobe_b) begin
            mon_addr_next = mon_addr_reg + INC;
        end else if (strobe_a) begin
            mon_addr_next = jdo[ADDR_W+9:10];
            jtag_rd_req   = jdo[35];
        end else if (strobe_n && last_rd_reg) begin
            mon_addr_next = mon_addr_reg + INC;
            jtag_rd_req   = 1'b1;
        end
    end

    // The JTAG path never reaches the control word; reset suppresses any in-flight write.
    assign jtag_rd_issue = jtag_rd_req && (mon_addr_next != TOP);
    assign jtag_wr       = strobe_b && (mon_addr_reg != TOP) && reset_n;

    assign av.av_waitrequest = reset_n & (take_action_ocimem_a | take_action_ocimem_b |
                                          take_no_action_ocimem_a | jtag_rd_pend_reg);
    assign av_rd_acc = av.av_read  & ~av.av_waitrequest;
    assign av_wr_acc = av.av_write & ~av.av_waitrequest;
    assign av_is_top = (av.av_address == TOP);
    // Flag writes only set bits, so they act even while stalled and a held write is harmless.
    assign ctrl_wr   = av.av_write & av_is_top;

    assign ram_we = jtag_wr | (av_wr_acc & ~av_is_top & reset_n);
    assign ram_wa = jtag_wr ? mon_addr_reg : av.av_address;
    assign ram_wd = jtag_wr ? jdo[34:3]    : av.av_writedata;
    assign ram_be = jtag_wr ? 4'hF         : av.av_byteenable;
    assign ram_ra = jtag_rd_issue ? mon_addr_next : av.av_address;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] ram_lane [DEPTH];
            logic [7:0] q_lane;
            always_ff @(posedge clk) begin
                if (ram_we && ram_be[gi]) begin
                    ram_lane[ram_wa] <= ram_wd[8*gi +: 8];
                end
                q_lane <= ram_lane[ram_ra];
            end
            assign ram_q[8*gi +: 8] = q_lane;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mon_addr_reg        <= '0;
            last_rd_reg         <= 1'b0;
            jtag_rd_pend_reg    <= 1'b0;
            MonDReg             <= '0;
            monitor_ready       <= 1'b0;
            monitor_error       <= 1'b0;
            monitor_go          <= 1'b0;
            av_rd_pend_reg      <= 1'b0;
            av_rd_ctrl_reg      <= 1'b0;
            ctrl_snap_reg       <= '0;
            av.av_readdata      <= '0;
            av.av_readdatavalid <= 1'b0;
        end else begin
            mon_addr_reg     <= mon_addr_next;
            jtag_rd_pend_reg <= jtag_rd_issue;
            if (strobe_b) begin
                last_rd_reg <= 1'b0;
            end else if (strobe_a) begin
                last_rd_reg <= jdo[35];
            end

            if (strobe_b) begin
                MonDReg <= jdo[34:3];
            end else if (jtag_rd_pend_reg) begin
                MonDReg <= ram_q;
            end

            if (strobe_a && jdo[32]) begin
                monitor_ready <= 1'b0;
            end else if (ctrl_wr && av.av_writedata[0]) begin
                monitor_ready <= 1'b1;
            end
            if (strobe_a && jdo[33]) begin
                monitor_error <= 1'b0;
            end else if (ctrl_wr && av.av_writedata[1]) begin
                monitor_error <= 1'b1;
            end
            if (strobe_a && jdo[34]) begin
                monitor_go <= 1'b1;
            end else if (av_rd_acc && av_is_top) begin
                monitor_go <= 1'b0;
            end

            // Control-word reads are snapshotted at acceptance so they share the RAM latency.
            av_rd_pend_reg <= av_rd_acc;
            if (av_rd_acc) begin
                av_rd_ctrl_reg <= av_is_top;
                ctrl_snap_reg  <= {monitor_go, monitor_error, monitor_ready};
            end
            av.av_readdatavalid <= av_rd_pend_reg;
            if (av_rd_pend_reg) begin
                av.av_readdata <= av_rd_ctrl_reg ? {29'b0, ctrl_snap_reg} : ram_q;
            end
        end
    end
endmodule

// File: tb/tb_nios_system_sdram_nios2_qsys_0_jtag_monitor_mem.sv
// Directed and randomized checks of the JTAG monitor memory against a word-level reference model.
module tb_nios_system_sdram_nios2_qsys_0_jtag_monitor_mem;
    localparam int        ADDR_W = 8;
    localparam logic [7:0] TOP   = 8'hFF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error, monitor_go;

    nios_system_sdram_nios2_qsys_0_jtag_monitor_mem_if #(.ADDR_W(ADDR_W)) av_bus ();

    nios_system_sdram_nios2_qsys_0_jtag_monitor_mem #(.ADDR_W(ADDR_W)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .av                      (av_bus),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .monitor_go              (monitor_go)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: word-addressed memory, monitor address and flags.
    logic [31:0] mdl_ram [256];
    logic [7:0]  mdl_addr;
    bit          mdl_rdy, mdl_err, mdl_go;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic jtag_a(input logic [7:0] addr, input bit rd, input bit go_set,
                          input bit clr_err, input bit clr_rdy);
        jdo = {2'($urandom_range(0, 3)), rd, go_set, clr_err, clr_rdy, 14'b0, addr,
               10'($urandom_range(0, 1023))};
        take_action_ocimem_a = 1'b1;
        #1;
        check("wait_cmd_a", av_bus.av_waitrequest, 1);
        tick;
        take_action_ocimem_a = 1'b0;
        mdl_addr = addr;
        if (go_set)  mdl_go  = 1'b1;
        if (clr_err) mdl_err = 1'b0;
        if (clr_rdy) mdl_rdy = 1'b0;
        $display("jtag cmd_a addr=%h rd=%0d go=%0d clr_err=%0d clr_rdy=%0d", addr, rd, go_set, clr_err, clr_rdy);
    endtask

    task automatic jtag_b(input logic [31:0] data);
        jdo = {3'($urandom_range(0, 7)), data, 3'($urandom_range(0, 7))};
        take_action_ocimem_b = 1'b1;
        #1;
        check("wait_cmd_b", av_bus.av_waitrequest, 1);
        tick;
        take_action_ocimem_b = 1'b0;
        $display("jtag cmd_b addr=%h data=%h", mdl_addr, data);
        if (mdl_addr != TOP) mdl_ram[mdl_addr] = data;
        mdl_addr = mdl_addr + 8'd1;
        check("mondreg_write", MonDReg, data);
    endtask

    // One read command followed by n auto-increment reads, issued back to back.
    task automatic jtag_read_burst(input logic [7:0] addr, input int n);
        logic [31:0] exp_q [$];
        jdo = {2'b0, 1'b1, 3'b000, 14'b0, addr, 10'($urandom_range(0, 1023))};
        take_action_ocimem_a = 1'b1;
        mdl_addr = addr;
        exp_q.push_back(mdl_ram[mdl_addr]);
        for (int i = 1; i <= n + 1; i++) begin
            tick;
            take_action_ocimem_a    = 1'b0;
            take_no_action_ocimem_a = 1'b0;
            if (i >= 2) check("mondreg_read", MonDReg, exp_q[i-2]);
            if (i <= n) begin
                take_no_action_ocimem_a = 1'b1;
                mdl_addr = mdl_addr + 8'd1;
                exp_q.push_back(mdl_ram[mdl_addr]);
            end
        end
        tick;
        check("mondreg_read", MonDReg, exp_q[n]);
        $display("jtag read burst addr=%h count=%0d", addr, n + 1);
    endtask

    task automatic av_rd(input logic [7:0] addr);
        logic [31:0] exp;
        int          budget;
        av_bus.av_address = addr;
        av_bus.av_read    = 1'b1;
        #1;
        budget = 0;
        while (av_bus.av_waitrequest && budget < 20) begin
            tick;
            budget++;
        end
        check("av_rd_accept", av_bus.av_waitrequest, 0);
        exp = (addr == TOP) ? {29'b0, mdl_go, mdl_err, mdl_rdy} : mdl_ram[addr];
        if (addr == TOP) mdl_go = 1'b0;
        tick;
        av_bus.av_read = 1'b0;
        check("av_valid_early", av_bus.av_readdatavalid, 0);
        tick;
        check("av_valid", av_bus.av_readdatavalid, 1);
        check("av_rdata", av_bus.av_readdata, exp);
        $display("av read addr=%h data=%h", addr, av_bus.av_readdata);
    endtask

    task automatic av_wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
        int budget;
        av_bus.av_address    = addr;
        av_bus.av_writedata  = data;
        av_bus.av_byteenable = be;
        av_bus.av_write      = 1'b1;
        #1;
        budget = 0;
        while (av_bus.av_waitrequest && budget < 20) begin
            tick;
            budget++;
        end
        check("av_wr_accept", av_bus.av_waitrequest, 0);
        tick;
        av_bus.av_write = 1'b0;
        if (addr == TOP) begin
            if (data[0]) mdl_rdy = 1'b1;
            if (data[1]) mdl_err = 1'b1;
        end else begin
            for (int k = 0; k < 4; k++)
                if (be[k]) mdl_ram[addr][8*k +: 8] = data[8*k +: 8];
        end
        $display("av write addr=%h data=%h be=%h", addr, data, be);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  a;
        logic [31:0] d;
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        av_bus.av_address = '0;
        av_bus.av_read = 1'b0;
        av_bus.av_write = 1'b0;
        av_bus.av_writedata = '0;
        av_bus.av_byteenable = '0;
        mdl_addr = '0;
        mdl_rdy = 1'b0;
        mdl_err = 1'b0;
        mdl_go = 1'b0;
        for (int i = 0; i < 256; i++) mdl_ram[i] = '0;

        repeat (3) tick;
        check("rst_mondreg", MonDReg, 0);
        check("rst_ready", monitor_ready, 0);
        check("rst_error", monitor_error, 0);
        check("rst_go", monitor_go, 0);
        check("rst_rdata", av_bus.av_readdata, 0);
        check("rst_rvalid", av_bus.av_readdatavalid, 0);
        check("rst_wait", av_bus.av_waitrequest, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick;

        // Write DEADBEEF at 0x10 then two more words that land at 0x11 and 0x12.
        jtag_a(8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
        jtag_b(32'hDEADBEEF);
        jtag_b($urandom);
        jtag_b($urandom);
        av_rd(8'h10);
        jtag_read_burst(8'h10, 2);

        // Wrap across the control word.
        jtag_a(8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) jtag_b($urandom);
        av_rd(8'h00);
        av_rd(8'hFE);
        jtag_b($urandom);
        av_rd(8'h01);
        av_rd(TOP);

        // Avalon read colliding with a JTAG read command.
        av_wr(8'h20, $urandom, 4'hF);
        av_bus.av_address = 8'h20;
        av_bus.av_read = 1'b1;
        jtag_a(8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
        check("race_wait_next", av_bus.av_waitrequest, 1);
        tick;
        check("race_wait_free", av_bus.av_waitrequest, 0);
        check("race_mondreg", MonDReg, mdl_ram[8'h10]);
        tick;
        av_bus.av_read = 1'b0;
        check("race_valid_early", av_bus.av_readdatavalid, 0);
        tick;
        check("race_valid", av_bus.av_readdatavalid, 1);
        check("race_rdata", av_bus.av_readdata, mdl_ram[8'h20]);
        tick;
        check("race_valid_pulse", av_bus.av_readdatavalid, 0);

        // Random full JTAG writes overlaid by random partial Avalon writes.
        for (int i = 0; i < 6; i++) begin
            a = 8'($urandom_range(8'h40, 8'hF0));
            jtag_a(a, 1'b0, 1'b0, 1'b0, 1'b0);
            jtag_b($urandom);
            av_wr(a, $urandom, 4'($urandom_range(0, 15)));
            av_rd(a);
            jtag_read_burst(a, 0);
        end

        // Control word flags and their JTAG/Avalon priorities.
        av_wr(TOP, 32'h1, 4'hF);
        check("ready_set", monitor_ready, mdl_rdy);
        av_bus.av_address = TOP;
        av_bus.av_writedata = 32'h3;
        av_bus.av_write = 1'b1;
        mdl_rdy = 1'b1;
        mdl_err = 1'b1;
        jtag_a(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        av_bus.av_write = 1'b0;
        check("race_ready", monitor_ready, mdl_rdy);
        check("race_error", monitor_error, mdl_err);
        av_rd(TOP);
        jtag_a(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("go_set", monitor_go, mdl_go);
        av_rd(TOP);
        check("go_cleared", monitor_go, mdl_go);
        jtag_a(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("error_cleared", monitor_error, mdl_err);

        // Reset in the middle of a JTAG write.
        d = $urandom;
        av_wr(8'h30, d, 4'hF);
        jtag_a(8'h30, 1'b0, 1'b1, 1'b0, 1'b0);
        jtag_b(~d);
        jtag_a(8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
        mdl_ram[8'h30] = d;
        av_wr(8'h30, d, 4'hF);
        jdo = {3'b0, ~d, 3'b0};
        take_action_ocimem_b = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_mid_mondreg", MonDReg, 0);
        check("rst_mid_go", monitor_go, 0);
        check("rst_mid_ready", monitor_ready, 0);
        check("rst_mid_error", monitor_error, 0);
        check("rst_mid_wait", av_bus.av_waitrequest, 0);
        check("rst_mid_rvalid", av_bus.av_readdatavalid, 0);
        check("rst_mid_rdata", av_bus.av_readdata, 0);
        tick;
        tick;
        take_action_ocimem_b = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        mdl_addr = '0;
        mdl_rdy = 1'b0;
        mdl_err = 1'b0;
        mdl_go = 1'b0;
        tick;
        av_rd(8'h30);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
